dmem_responder: RTL and testbench

Memory-side responder for the pipeline's data-memory port. It accepts one load or store request at a time from the CPU-side initiator over a valid/ready handshake and applies a configurable number of wait states. It performs the access on a 128-word array and returns the result over a second valid/ready handshake. It sits between the MEM stage's request interface and the data storage, so stall logic can be exercised against non-zero memory latency.

---
 rtl/mips_mem_pkg.sv | 16 +
 rtl/dmem_array.sv | 38 +++
 rtl/dmem_responder.sv | 113 +++++++++++
 tb/tb_dmem_responder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared constants and FSM state encoding for the data-memory responder.
package mips_mem_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 7;
  localparam int WAIT_MAX   = 15;
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous 2**ADDR_W x DATA_W storage, read-before-write, 1-cycle read latency.
// No backpressure: the access happens on every enabled edge; read data holds until the next enable.
module dmem_array #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage itself has no reset; only the output register does.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (en_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// One-outstanding load/store responder; access at acceptance edge + 1 + WAIT_CYCLES, turnaround WAIT_CYCLES + 3.
// req_ready only in IDLE; response held in RESP until rsp_ready, no queueing.
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_write,
  output logic              busy
);

  localparam int WAIT_EFF   = (WAIT_CYCLES > WAIT_MAX) ? WAIT_MAX : WAIT_CYCLES;
  localparam int WAIT_INIT_I = (WAIT_EFF > 0) ? (WAIT_EFF - 1) : 0;
  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_INIT_I[WAIT_CNT_W-1:0];

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } hold_t;

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  hold_t                 hold_q, hold_d;
  logic                  arr_en;
  logic [DATA_W-1:0]     arr_rdata;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      hold_q     <= hold_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    hold_d     = hold_q;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    arr_en     = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          hold_d.write = req_write;
          hold_d.addr  = req_addr;
          hold_d.wdata = req_wdata;
          if (WAIT_EFF > 0) begin
            state_d    = WAIT;
            wait_cnt_d = WAIT_INIT;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      WAIT: begin
        if (wait_cnt_q == '0) begin
          state_d = ACCESS;
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_CNT_W'(1);
        end
      end
      ACCESS: begin
        arr_en  = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  dmem_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .en_i   (arr_en),
    .we_i   (hold_q.write),
    .addr_i (hold_q.addr),
    .wdata_i(hold_q.wdata),
    .rdata_o(arr_rdata)
  );

  // Stores echo their own data; loads see the array's pre-write read register.
  assign rsp_rdata = hold_q.write ? hold_q.wdata : arr_rdata;
  assign rsp_write = hold_q.write;
  assign busy      = (state_q == WAIT) || (state_q == RESP);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: three responders with WAIT_CYCLES = 2, 0 and 3 on a shared clock.
module tb_dmem_responder;

  localparam int NI = 3;
  localparam int P2 = 0;
  localparam int P0 = 1;
  localparam int P3 = 2;

  logic        clk = 1'b0;
  logic        rst_n     [NI];
  logic        req_valid [NI];
  logic        req_ready [NI];
  logic        req_write [NI];
  logic [6:0]  req_addr  [NI];
  logic [31:0] req_wdata [NI];
  logic        rsp_valid [NI];
  logic        rsp_ready [NI];
  logic [31:0] rsp_rdata [NI];
  logic        rsp_write [NI];
  logic        busy      [NI];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dmem_responder #(
      .DATA_W     (32),
      .ADDR_W     (7),
      .WAIT_CYCLES((g == 0) ? 2 : ((g == 1) ? 0 : 3))
    ) u_dut (
      .CLK      (clk),
      .RST_N    (rst_n[g]),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_write(req_write[g]),
      .req_addr (req_addr[g]),
      .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_write(rsp_write[g]),
      .busy     (busy[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    chk(tag, {31'b0, got}, {31'b0, exp});
  endtask

  function automatic int wc(input int p);
    return (p == P2) ? 2 : ((p == P0) ? 0 : 3);
  endfunction

  // Returns right at the accepting posedge; req_valid is left as it was.
  task automatic wait_acc(input int p, output logic acc);
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = req_ready[p];
      @(posedge clk);
    end
  endtask

  task automatic issue(input int p, input logic w, input logic [6:0] a, input logic [31:0] d);
    logic acc;
    req_valid[p] = 1'b1;
    req_write[p] = w;
    req_addr[p]  = a;
    req_wdata[p] = d;
    wait_acc(p, acc);
    #1;
    req_valid[p] = 1'b0;
    if (!acc) chk1("accept_timeout", 1'b0, 1'b1);
  endtask

  // Counts falling edges after acceptance until rsp_valid is seen.
  task automatic wait_rsp(input int p, output int cyc);
    cyc = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (rsp_valid[p]) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) chk1("rsp_timeout", 1'b0, 1'b1);
  endtask

  task automatic consume(input int p);
    rsp_ready[p] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[p] = 1'b0;
  endtask

  task automatic txn(input string tag, input int p, input logic w, input logic [6:0] a,
                     input logic [31:0] d, input logic [31:0] exp);
    int cyc;
    issue(p, w, a, d);
    wait_rsp(p, cyc);
    chk({tag, "_lat"}, 32'(cyc), 32'(wc(p) + 2));
    chk1({tag, "_wr"}, rsp_write[p], w);
    chk({tag, "_data"}, rsp_rdata[p], exp);
    consume(p);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal;
  end

  initial begin
    int   cyc;
    logic acc;
    for (int p = 0; p < NI; p++) begin
      rst_n[p]     = 1'b0;
      req_valid[p] = 1'b0;
      req_write[p] = 1'b0;
      req_addr[p]  = 7'd0;
      req_wdata[p] = 32'h0;
      rsp_ready[p] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int p = 0; p < NI; p++) rst_n[p] = 1'b1;
    for (int p = 0; p < NI; p++) begin
      chk1("init_req_ready", req_ready[p], 1'b1);
      chk1("init_busy", busy[p], 1'b0);
    end
    @(posedge clk);
    #1;

    // Asynchronous reset while a store response is pending (store already committed).
    issue(P2, 1'b1, 7'd9, 32'hAAAA5555);
    wait_rsp(P2, cyc);
    chk1("pre_rst_valid", rsp_valid[P2], 1'b1);
    chk1("pre_rst_busy", busy[P2], 1'b1);
    chk("pre_rst_data", rsp_rdata[P2], 32'hAAAA5555);
    #2;
    rst_n[P2] = 1'b0;
    #1;
    chk1("rst_req_ready", req_ready[P2], 1'b1);
    chk1("rst_rsp_valid", rsp_valid[P2], 1'b0);
    chk1("rst_busy", busy[P2], 1'b0);
    chk("rst_rdata", rsp_rdata[P2], 32'h0);
    chk1("rst_rsp_write", rsp_write[P2], 1'b0);
    @(negedge clk);
    rst_n[P2] = 1'b1;
    @(posedge clk);
    #1;

    // Store then load, WAIT_CYCLES = 2.
    txn("st5", P2, 1'b1, 7'd5, 32'hDEADBEEF, 32'hDEADBEEF);
    txn("ld5", P2, 1'b0, 7'd5, 32'h0, 32'hDEADBEEF);
    txn("ld9", P2, 1'b0, 7'd9, 32'h0, 32'hAAAA5555);

    // WAIT_CYCLES = 0 latency and minimum turnaround with rsp_ready tied high.
    txn("w0_st0", P0, 1'b1, 7'd0, 32'h0BADF00D, 32'h0BADF00D);
    req_valid[P0] = 1'b1;
    req_write[P0] = 1'b0;
    req_addr[P0]  = 7'd0;
    rsp_ready[P0] = 1'b1;
    wait_acc(P0, acc);
    #1;
    if (!acc) chk1("w0_accept_timeout", 1'b0, 1'b1);
    req_write[P0] = 1'b1;
    req_addr[P0]  = 7'd1;
    req_wdata[P0] = 32'h000000A5;
    @(negedge clk);
    chk1("w0_acc_valid", rsp_valid[P0], 1'b0);
    chk1("w0_acc_ready", req_ready[P0], 1'b0);
    @(negedge clk);
    chk1("w0_resp_valid", rsp_valid[P0], 1'b1);
    chk("w0_resp_data", rsp_rdata[P0], 32'h0BADF00D);
    chk1("w0_resp_ready", req_ready[P0], 1'b0);
    @(negedge clk);
    chk1("w0_idle_ready", req_ready[P0], 1'b1);
    chk1("w0_idle_valid", rsp_valid[P0], 1'b0);
    @(posedge clk);
    #1;
    req_valid[P0] = 1'b0;
    rsp_ready[P0] = 1'b0;
    wait_rsp(P0, cyc);
    chk("w0_b2b_lat", 32'(cyc), 32'd2);
    chk1("w0_b2b_wr", rsp_write[P0], 1'b1);
    chk("w0_b2b_data", rsp_rdata[P0], 32'h000000A5);
    consume(P0);
    txn("w0_ld1", P0, 1'b0, 7'd1, 32'h0, 32'h000000A5);

    // Response backpressure with a second request waiting.
    issue(P2, 1'b0, 7'd5, 32'h0);
    wait_rsp(P2, cyc);
    chk("bp_lat", 32'(cyc), 32'd4);
    req_valid[P2] = 1'b1;
    req_write[P2] = 1'b1;
    req_addr[P2]  = 7'd6;
    req_wdata[P2] = 32'h11112222;
    for (int i = 0; i < 5; i++) begin
      chk1("bp_valid", rsp_valid[P2], 1'b1);
      chk("bp_data", rsp_rdata[P2], 32'hDEADBEEF);
      chk1("bp_req_ready", req_ready[P2], 1'b0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rsp_ready[P2] = 1'b1;
    @(negedge clk);
    chk1("bp_hs_req_ready", req_ready[P2], 1'b0);
    chk1("bp_hs_valid", rsp_valid[P2], 1'b1);
    @(posedge clk);
    #1;
    rsp_ready[P2] = 1'b0;
    @(negedge clk);
    chk1("bp_idle_ready", req_ready[P2], 1'b1);
    @(posedge clk);
    #1;
    req_valid[P2] = 1'b0;
    wait_rsp(P2, cyc);
    chk("bp2_lat", 32'(cyc), 32'd4);
    chk1("bp2_wr", rsp_write[P2], 1'b1);
    chk("bp2_data", rsp_rdata[P2], 32'h11112222);
    consume(P2);

    // Reset in the second WAIT cycle drops the store, WAIT_CYCLES = 3.
    txn("w3_clr", P3, 1'b1, 7'd127, 32'h0, 32'h0);
    issue(P3, 1'b1, 7'd127, 32'h12345678);
    @(posedge clk);
    #2;
    chk1("w3_wait_busy", busy[P3], 1'b1);
    chk1("w3_wait_ready", req_ready[P3], 1'b0);
    rst_n[P3] = 1'b0;
    #1;
    chk1("w3_rst_busy", busy[P3], 1'b0);
    chk1("w3_rst_ready", req_ready[P3], 1'b1);
    @(negedge clk);
    rst_n[P3] = 1'b1;
    @(posedge clk);
    #1;
    txn("w3_ld127", P3, 1'b0, 7'd127, 32'h0, 32'h0);

    // Address boundaries, no aliasing.
    txn("st0", P2, 1'b1, 7'd0, 32'h00000001, 32'h00000001);
    txn("st127", P2, 1'b1, 7'd127, 32'hFFFFFFFF, 32'hFFFFFFFF);
    txn("ld0", P2, 1'b0, 7'd0, 32'h0, 32'h00000001);
    txn("ld127", P2, 1'b0, 7'd127, 32'h0, 32'hFFFFFFFF);
    txn("ld6", P2, 1'b0, 7'd6, 32'h0, 32'h11112222);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
